immediate_generate_pipe: RTL
============================

# immediate_generate_pipe

Registered, flow-controlled successor to the combinational immediate generator. Decodes the immediate field of instruction bits [31:7] for all eight IMM_SEL formats, sign- or zero-extends it to XLEN, and delivers it through a valid/ready stage with a two-entry skid buffer. Sits at the ID/EX boundary so decode stalls and flushes can be absorbed without re-decoding.

## Interface
- XLEN, 32: datapath width; legal values 32 and 64.
- CLK  in  1  rising-edge clock
- RESET  in  1  synchronous, active-high reset
- FLUSH  in  1  synchronous kill of all buffered entries
- IN  in  25  instruction[31:7]; inst[i] = IN[i-7]
- IMM_SEL  in  3  format select
- PC_IN  in  XLEN  PC of the instruction, carried alongside
- IN_VALID  in  1  upstream entry valid
- IN_READY  out  1  stage can accept
- OUT_VALID  out  1  output entry valid
- OUT_READY  in  1  downstream accepts
- OUT_IMM  out  XLEN  extended immediate
- OUT_PC  out  XLEN  PC of the output entry
- OUT_TARGET  out  XLEN  PC+immediate (IMM_PC_ADD_EN only)

## Operation
- IMM_SEL (sext = sign-extend from inst[31] to XLEN, zext = zero-extend):
  - 000 U: sext{inst[31:12], 12'b0}
  - 001 J: sext{inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}
  - 010 B: sext{inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}
  - 011 I: sext{inst[31:20]}
  - 100 IU: zext{inst[31:20]}
  - 101 S: sext{inst[31:25], inst[11:7]}
  - 110 SFT: zext inst[24:20] (XLEN=32) / inst[25:20] (XLEN=64)
  - 111 CSR zimm: zext inst[19:15]
- Decode is combinational on the input side; only decoded values (not raw IN/IMM_SEL) are stored.
- Storage: output register (OUT_*) plus one skid register. FIFO order always preserved.
- Accept when IN_VALID && IN_READY; deliver when OUT_VALID && OUT_READY.
- IN_READY = skid register empty (registered, no combinational path from OUT_READY).
- Accept with output empty or draining: entry goes to output register. Accept with output held: entry goes to skid. On drain with skid full: skid moves to output register, IN_READY rises next cycle.
- FLUSH: next cycle OUT_VALID=0, skid empty, IN_READY=1; any same-cycle input is discarded. RESET has priority over FLUSH.

## Timing
- Reset values: OUT_VALID=0, IN_READY=1, OUT_IMM=0, OUT_PC=0, OUT_TARGET=0.
- Latency: 1 cycle from accept to OUT_VALID with empty stage.
- Throughput: 1 entry/cycle while OUT_READY=1.
- While OUT_VALID && !OUT_READY, OUT_IMM/OUT_PC/OUT_TARGET are stable.
- Both registers full: IN_READY=0; IN_VALID ignored.
- Simultaneous accept and deliver with skid empty: output register reloads, no bubble.
- RESET mid-stream: all entries dropped next cycle, outputs return to reset values.

## Configuration
- IMM_PC_ADD_EN defined: OUT_TARGET = PC_IN + immediate (XLEN-bit, wrap-around on overflow), computed before the register and buffered with its entry.
- Undefined: adder and storage omitted; OUT_TARGET tied to 0.

## Test plan
- XLEN=32, IN=0xFFF00093>>7, IMM_SEL=011 -> OUT_IMM=0xFFFFFFFF one cycle later; same IN, IMM_SEL=100 -> 0x00000FFF.
- J 0xFFDFF06F -> 0xFFFFFFFC; B 0x00000463 -> 0x00000008; S 0xFE112E23 -> 0xFFFFFFFC; SFT 0x01F09093 -> 0x1F.
- XLEN=64, U 0x800000B7 -> 0xFFFFFFFF80000000; SFT 0x03F09093 -> 0x3F.
- OUT_READY=0 for 3 cycles, IN_VALID held with three entries A,B,C -> A,B accepted, IN_READY=0 on cycle 3, C held; release -> A,B,C delivered in order, no drops.
- Both registers full, FLUSH=1 with IN_VALID=1 -> next cycle OUT_VALID=0, IN_READY=1, flushed entry never appears.
- IMM_PC_ADD_EN, PC_IN=0x100, J imm -4 -> OUT_TARGET=0x0FC; PC_IN=0xFFFFFFFC, B imm +8 -> OUT_TARGET=0x00000004.

Source files
------------

// File: rtl/immediate_generate_pipe.sv
// Immediate decoder behind a valid/ready stage with a two-entry skid buffer (output + skid register).
// Optional macro IMM_PC_ADD_EN adds a PC+immediate target carried alongside each entry.
module immediate_generate_pipe #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            FLUSH,
  input  logic [24:0]     IN,
  input  logic [2:0]      IMM_SEL,
  input  logic [XLEN-1:0] PC_IN,
  input  logic            IN_VALID,
  output logic            IN_READY,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [XLEN-1:0] OUT_IMM,
  output logic [XLEN-1:0] OUT_PC,
  output logic [XLEN-1:0] OUT_TARGET
);

  // The function argument is indexed with instruction bit numbers so the format table reads directly.
  function automatic logic signed [XLEN-1:0] decode_imm(input logic [31:7] inst,
                                                       input logic [2:0]  sel);
    logic [31:0] raw;
    logic        sx;
    raw = '0;
    sx  = 1'b1;
    unique case (sel)
      3'd0: raw = {inst[31:12], 12'b0};
      3'd1: raw = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      3'd2: raw = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      3'd3: raw = {{20{inst[31]}}, inst[31:20]};
      3'd4: begin raw = {20'b0, inst[31:20]}; sx = 1'b0; end
      3'd5: raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      3'd6: begin
        raw = (XLEN == 64) ? {26'b0, inst[25:20]} : {27'b0, inst[24:20]};
        sx  = 1'b0;
      end
      default: begin raw = {27'b0, inst[19:15]}; sx = 1'b0; end
    endcase
    return sx ? XLEN'($signed(raw)) : XLEN'(raw);
  endfunction

  // ---- p0: combinational decode of the incoming entry ----
  logic signed [XLEN-1:0] imm_p0;
  logic                   accept, out_free;
  logic                   load_skid_to_out, load_in_to_out, load_in_to_skid;

  logic                   vld_p1, skid_vld_p1;
  logic signed [XLEN-1:0] out_imm_p1, skid_imm_p1;
  logic [XLEN-1:0]        out_pc_p1, skid_pc_p1;

  assign imm_p0   = decode_imm(IN, IMM_SEL);
  assign accept   = IN_VALID && !skid_vld_p1;
  assign out_free = !vld_p1 || OUT_READY;

  // A full skid always drains first, which keeps FIFO order without comparing ages.
  assign load_skid_to_out = out_free && skid_vld_p1;
  assign load_in_to_out   = out_free && !skid_vld_p1 && accept;
  assign load_in_to_skid  = !out_free && accept;

  // ---- p1: output register and skid register ----
  always_ff @(posedge CLK) begin
    if (RESET || FLUSH) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else begin
      vld_p1      <= load_skid_to_out || load_in_to_out || (vld_p1 && !OUT_READY);
      skid_vld_p1 <= (skid_vld_p1 && !out_free) || load_in_to_skid;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_imm_p1 <= '0;
      out_pc_p1  <= '0;
    end else if (load_skid_to_out) begin
      out_imm_p1 <= skid_imm_p1;
      out_pc_p1  <= skid_pc_p1;
    end else if (load_in_to_out) begin
      out_imm_p1 <= imm_p0;
      out_pc_p1  <= PC_IN;
    end
  end

  always_ff @(posedge CLK) begin
    if (load_in_to_skid) begin
      skid_imm_p1 <= imm_p0;
      skid_pc_p1  <= PC_IN;
    end
  end

`ifdef IMM_PC_ADD_EN
  logic [XLEN-1:0] tgt_p0, out_tgt_p1, skid_tgt_p1;

  assign tgt_p0 = PC_IN + $unsigned(imm_p0);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_tgt_p1 <= '0;
    end else if (load_skid_to_out) begin
      out_tgt_p1 <= skid_tgt_p1;
    end else if (load_in_to_out) begin
      out_tgt_p1 <= tgt_p0;
    end
  end

  always_ff @(posedge CLK) begin
    if (load_in_to_skid) begin
      skid_tgt_p1 <= tgt_p0;
    end
  end

  assign OUT_TARGET = out_tgt_p1;
`else
  assign OUT_TARGET = '0;
`endif

  assign IN_READY  = !skid_vld_p1;
  assign OUT_VALID = vld_p1;
  assign OUT_IMM   = $unsigned(out_imm_p1);
  assign OUT_PC    = out_pc_p1;

endmodule
